// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and helpers for the riscv memory-bus arbiter
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    localparam int STARVE_W = 4;

    // Saturating increment for the fetch starvation counter
    function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v,
                                                    input logic [STARVE_W-1:0] lim);
        return (v >= lim) ? lim : v + 4'd1;
    endfunction

    // Fetch must win once it has been passed over lim times in a row
    function automatic logic fetch_forced(input logic [STARVE_W-1:0] cnt,
                                          input logic [STARVE_W-1:0] lim);
        return cnt >= lim;
    endfunction

endpackage

// File: rtl/riscv_membus_arb_pick.sv
// rtl/riscv_membus_arb_pick.sv - next-grant selection (RISCV_MEMBUS_ARB_RR_EN selects round-robin)
module riscv_membus_arb_pick
    import riscv_pkg::*;
(
    input  logic                imem_req,
    input  logic                dmem_req,
`ifdef RISCV_MEMBUS_ARB_RR_EN
    input  logic                last_gnt_d,
`else
    input  logic [STARVE_W-1:0] starve_cnt,
    input  logic [STARVE_W-1:0] limit,
`endif
    output logic                gnt_d
);

    // Data wins unless fetch also requests and is owed the slot
    always_comb begin
`ifdef RISCV_MEMBUS_ARB_RR_EN
        gnt_d = dmem_req && !(imem_req && last_gnt_d);
`else
        gnt_d = dmem_req && !(imem_req && fetch_forced(starve_cnt, limit));
`endif
    end

endmodule

// File: rtl/riscv_membus_arb.sv
// rtl/riscv_membus_arb.sv - fetch/data arbiter onto one memory port (macro RISCV_MEMBUS_ARB_RR_EN: round-robin)
module riscv_membus_arb
    import riscv_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_req,
    input  logic [XLEN-1:0]   imem_adr,
    output logic              imem_ack,
    output logic              imem_err,
    output logic [XLEN-1:0]   imem_q,
    input  logic              dmem_req,
    input  logic              dmem_we,
    input  logic [XLEN/8-1:0] dmem_be,
    input  logic [XLEN-1:0]   dmem_adr,
    input  logic [XLEN-1:0]   dmem_d,
    output logic              dmem_ack,
    output logic              dmem_err,
    output logic [XLEN-1:0]   dmem_q,
    output logic              bus_req,
    output logic              bus_we,
    output logic [XLEN/8-1:0] bus_be,
    output logic [XLEN-1:0]   bus_adr,
    output logic [XLEN-1:0]   bus_d,
    input  logic              bus_ack,
    input  logic              bus_err,
    input  logic [XLEN-1:0]   bus_q
);

    arb_state_t state;
    logic       pick_d;
    logic       any_req;
    logic       grant_now;

    assign any_req   = imem_req | dmem_req;
    assign grant_now = (state == IDLE) && any_req;

`ifdef RISCV_MEMBUS_ARB_RR_EN
    logic last_gnt_d;

    riscv_membus_arb_pick u_pick (
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .last_gnt_d (last_gnt_d),
        .gnt_d      (pick_d)
    );

    // Remember who won the last grant so contention alternates
    always_ff @(posedge clk) begin
        if (rst)
            last_gnt_d <= 1'b0;
        else if (grant_now)
            last_gnt_d <= pick_d;
    end
`else
    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);
    logic [STARVE_W-1:0] starve_cnt;

    riscv_membus_arb_pick u_pick (
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .starve_cnt (starve_cnt),
        .limit      (LIMIT),
        .gnt_d      (pick_d)
    );

    // Count data grants that overtook a waiting fetch; a fetch grant clears it
    always_ff @(posedge clk) begin
        if (rst)
            starve_cnt <= '0;
        else if (grant_now) begin
            if (!pick_d)
                starve_cnt <= '0;
            else if (imem_req)
                starve_cnt <= sat_inc(starve_cnt, LIMIT);
        end
    end
`endif

    // Grant FSM: one transaction at a time, back to IDLE on ack or abort
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else begin
            case (state)
                IDLE:    if (any_req) state <= pick_d ? GNT_D : GNT_I;
                GNT_I:   if (bus_ack || !imem_req) state <= IDLE;
                GNT_D:   if (bus_ack || !dmem_req) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Bus mux and zero-latency response routing to the granted side only
    always_comb begin
        bus_req  = 1'b0;
        bus_we   = 1'b0;
        bus_be   = '0;
        bus_adr  = '0;
        bus_d    = '0;
        imem_ack = 1'b0;
        imem_err = 1'b0;
        imem_q   = '0;
        dmem_ack = 1'b0;
        dmem_err = 1'b0;
        dmem_q   = '0;
        if (!rst) begin
            case (state)
                GNT_I: begin
                    bus_req  = imem_req;
                    bus_be   = '1;
                    bus_adr  = imem_adr;
                    imem_ack = bus_ack;
                    imem_err = bus_err;
                    imem_q   = bus_q;
                end
                GNT_D: begin
                    bus_req  = dmem_req;
                    bus_we   = dmem_we;
                    bus_be   = dmem_be;
                    bus_adr  = dmem_adr;
                    bus_d    = dmem_d;
                    dmem_ack = bus_ack;
                    dmem_err = bus_err;
                    dmem_q   = bus_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/riscv_membus_arb.md
RISCV_MEMBUS_ARB -- requirements
Module: riscv_membus_arb

Interface
REQ-001 SHALL have parameter XLEN, default 32: address and data width.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4: maximum number of consecutive data grants while a fetch request waits (range 1..15).
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have ports imem_req (in, 1), imem_adr (in, XLEN): instruction-fetch read request and address.
REQ-006 SHALL have ports imem_ack (out, 1), imem_err (out, 1), imem_q (out, XLEN): fetch completion, error flag and read data.
REQ-007 SHALL have ports dmem_req (in, 1), dmem_we (in, 1), dmem_be (in, XLEN/8), dmem_adr (in, XLEN), dmem_d (in, XLEN): data request, write enable, byte enables, address and write data.
REQ-008 SHALL have ports dmem_ack (out, 1), dmem_err (out, 1), dmem_q (out, XLEN): data completion, error flag and read data.
REQ-009 SHALL have ports bus_req, bus_we (out, 1), bus_be (out, XLEN/8), bus_adr, bus_d (out, XLEN): the shared memory port.
REQ-010 SHALL have ports bus_ack, bus_err (in, 1), bus_q (in, XLEN): shared port response.

Function
REQ-011 SHALL implement a 3-state FSM: IDLE, GNT_I, GNT_D; at most one bus transaction is outstanding at any time.
REQ-012 In IDLE, when any request is high, SHALL move to GNT_I or GNT_D on the next edge; bus_req is 0 while in IDLE.
REQ-013 In GNT_x, bus_req SHALL equal x_req, and bus_adr, bus_we, bus_be and bus_d SHALL be muxed from requester x; fetch drives bus_we=0 and bus_be all-ones.
REQ-014 Grant latency SHALL be 1 cycle: a request first seen at cycle N gives bus_req=1 at cycle N+1.
REQ-015 bus_ack, bus_err and bus_q SHALL be routed combinationally, with zero latency, to the granted requester only; the other requester's ack and err SHALL be 0.
REQ-016 Without an ack, the FSM SHALL hold GNT_x; requesters keep req and attributes stable until ack.
REQ-017 On bus_ack in GNT_x, SHALL return to IDLE; re-arbitration then costs 1 idle cycle per transaction.
REQ-018 Abort: if the granted x_req drops before bus_ack, SHALL return to IDLE on the next edge with bus_req=0.
REQ-019 bus_ack received in IDLE SHALL be ignored; no requester ack is generated.
REQ-020 Default priority SHALL be data over fetch when both requests are high in IDLE.
REQ-021 SHALL keep a starvation counter starve_cnt (4 bits): +1 on each GNT_D entry while imem_req=1; cleared on each GNT_I entry.
REQ-022 When starve_cnt equals STARVE_LIMIT and imem_req=1, the next grant SHALL go to fetch regardless of dmem_req.
REQ-023 starve_cnt SHALL saturate at STARVE_LIMIT and never wrap.

Reset
REQ-024 With rst=1 at a clock edge, SHALL set state to IDLE and starve_cnt to 0; a reset asserted mid-transaction SHALL abandon the transaction.
REQ-025 During reset and in the cycle after, bus_req, imem_ack, dmem_ack, imem_err and dmem_err SHALL be 0; bus_adr, bus_d, bus_be and bus_we SHALL be 0 in IDLE.

Configuration
REQ-026 Macro RISCV_MEMBUS_ARB_RR_EN defined: SHALL use round-robin; a last_gnt flop (reset value fetch) selects the requester not last granted on contention; starve_cnt is removed.
REQ-027 Macro RISCV_MEMBUS_ARB_RR_EN undefined: SHALL use data priority with the starvation counter (REQ-020..023).

Structure
REQ-028 The FSM state enum (IDLE, GNT_I, GNT_D) SHALL be a typedef in riscv_pkg.
REQ-029 Combinational next-grant selection SHALL be one sub-module, riscv_membus_arb_pick: inputs are requests, starve_cnt/last_gnt and the limit; output is the grant.

Verification
REQ-030 Fetch only: imem_req=1, imem_adr=0x200, bus_ack at cycle 3 with bus_q=0x00000013 -> bus_req=1 with bus_adr=0x200 at cycles 1-3, imem_ack=1 and imem_q=0x13 at cycle 3, state IDLE at cycle 4.
REQ-031 Contention: imem_req and dmem_req both held high, every grant acked after 1 cycle, STARVE_LIMIT=4 -> grants D,D,D,D,I,D,...
REQ-032 Write passthrough: dmem_we=1, dmem_be=4'b0011, dmem_d=0xDEADBEEF, bus_err=1 on ack -> bus_be=4'b0011, bus_d=0xDEADBEEF, dmem_err=1, imem_err=0.
REQ-033 Abort and reset: dmem_req drops at grant cycle 2 -> bus_req=0 at cycle 3; rst=1 mid-GNT_I -> IDLE with all outputs 0 the next cycle.
REQ-034 With RISCV_MEMBUS_ARB_RR_EN defined, both requests held -> grants D,I,D,I...; stray bus_ack in IDLE -> no requester ack.
